// File: rtl/arb_rr_lock.sv
// rtl/arb_rr_lock.sv - round-robin arbiter with packet locking and stall watchdog
module arb_rr_lock #(
  parameter int WIDTH   = 4,
  parameter int IDX_W   = $clog2(WIDTH),
  parameter int LOCK_TO = 16,
  parameter int TO_W    = $clog2(LOCK_TO + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_vld,
  input  logic [WIDTH-1:0] req_last,
  output logic [WIDTH-1:0] req_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  output logic [WIDTH-1:0] out_owner,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] prio,
  output logic             busy,
  output logic             err_timeout
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   prio_nxt, owner_nxt;
  logic [TO_W-1:0]    wd, wd_nxt;
  logic [2*WIDTH-1:0] dv, diff, gnt2;
  logic [WIDTH-1:0]   winner, rot;
  logic               own_vld;

  // Subtracting the pointer from the doubled request vector clears everything
  // below the first request at or circularly after prio.
  assign dv      = {req_vld, req_vld};
  assign diff    = dv - {{WIDTH{1'b0}}, prio};
  assign gnt2    = dv & ~diff;
  assign winner  = gnt2[WIDTH-1:0] | gnt2[2*WIDTH-1:WIDTH];
  assign rot     = {out_owner[WIDTH-2:0], out_owner[WIDTH-1]};
  assign own_vld = |(req_vld & out_owner);
  assign busy    = (state == LOCK);

  always_comb begin
    out_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (out_owner[i]) out_idx = out_idx | IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    prio_nxt    = prio;
    owner_nxt   = out_owner;
    wd_nxt      = wd;
    out_vld     = 1'b0;
    out_last    = 1'b0;
    req_rdy     = '0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (|req_vld) begin
          state_nxt = LOCK;
          owner_nxt = winner;
          wd_nxt    = '0;
        end
      end
      LOCK: begin
        out_vld  = own_vld;
        out_last = |(req_last & req_vld & out_owner);
        req_rdy  = out_owner & {WIDTH{out_rdy}};
        if (own_vld && out_rdy && out_last) begin
          state_nxt = IDLE;
          owner_nxt = '0;
          prio_nxt  = rot;
          wd_nxt    = '0;
        end else if (own_vld) begin
          wd_nxt = '0;
        end else if (wd == TO_W'(LOCK_TO - 1)) begin
          state_nxt   = IDLE;
          owner_nxt   = '0;
          prio_nxt    = rot;
          wd_nxt      = '0;
          err_timeout = 1'b1;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may be accepted or flagged while reset is being sampled.
    if (!rst_n) begin
      out_vld     = 1'b0;
      out_last    = 1'b0;
      req_rdy     = '0;
      err_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= WIDTH'(1);
      out_owner <= '0;
      wd        <= '0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      out_owner <= owner_nxt;
      wd        <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_arb_rr_lock.sv
// tb/tb_arb_rr_lock.sv - randomized and directed checks of arb_rr_lock against a behavioural model
module tb_arb_rr_lock;
  localparam int W  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] req_vld = '0, req_last = '0, req_rdy, out_owner, prio;
  logic         out_vld, out_rdy = 1'b0, out_last, busy, err_timeout;
  logic [1:0]   out_idx;
  logic [17:0]  obs, expv;

  int n_vec = 0;
  int n_err = 0;

  // Model state: owner index (-1 when free), priority index, stall count.
  int m_owner = -1;
  int m_prio  = 0;
  int m_wd    = 0;

  arb_rr_lock #(.WIDTH(W), .LOCK_TO(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_last(req_last),
    .req_rdy(req_rdy), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .out_owner(out_owner), .out_idx(out_idx), .prio(prio), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  assign obs = {req_rdy, out_vld, out_last, out_owner, out_idx, prio, busy, err_timeout};

  function automatic logic [17:0] model_out(input logic [3:0] v, input logic [3:0] l,
                                            input logic r, input logic rn);
    logic [3:0] own, rdy, pr;
    logic [1:0] idx;
    logic       ov, ol, et, bz;
    own = '0; idx = '0; rdy = '0; ov = 1'b0; ol = 1'b0; et = 1'b0; bz = 1'b0;
    pr  = 4'(1 << m_prio);
    if (m_owner >= 0) begin
      own = 4'(1 << m_owner);
      idx = 2'(m_owner);
      bz  = 1'b1;
      if (rn) begin
        ov  = v[m_owner];
        ol  = v[m_owner] & l[m_owner];
        rdy = r ? own : 4'b0000;
        et  = !v[m_owner] && (m_wd + 1 == TO);
      end
    end
    return {rdy, ov, ol, own, idx, pr, bz, et};
  endfunction

  task automatic model_update(input logic [3:0] v, input logic [3:0] l,
                              input logic r, input logic rn);
    if (!rn) begin
      m_owner = -1; m_prio = 0; m_wd = 0;
    end else if (m_owner < 0) begin
      if (v != 0) begin
        for (int k = 0; k < W; k++) begin
          if (m_owner < 0 && v[(m_prio + k) % W]) m_owner = (m_prio + k) % W;
        end
        m_wd = 0;
      end
    end else if (v[m_owner] && r && l[m_owner]) begin
      m_prio = (m_owner + 1) % W; m_owner = -1; m_wd = 0;
    end else if (v[m_owner]) begin
      m_wd = 0;
    end else if (m_wd + 1 == TO) begin
      m_prio = (m_owner + 1) % W; m_owner = -1; m_wd = 0;
    end else begin
      m_wd++;
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r, input logic rn);
    @(negedge clk);
    req_vld = v; req_last = l; out_rdy = r; rst_n = rn;
    #1;
    expv = model_out(v, l, r, rn);
  endtask

  task automatic tick;
    @(posedge clk);
    model_update(req_vld, req_last, out_rdy, rst_n);
  endtask

  task automatic test_reset;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0); tick;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0); tick;
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    n_vec++;
    if (obs !== 18'(4'b0001 << 2)) begin
      $display("FAIL reset_state obs=%h exp=%h", obs, 18'(4'b0001 << 2)); n_err++;
    end
    n_vec++;
    if (obs !== expv) begin $display("FAIL reset_model obs=%h exp=%h", obs, expv); n_err++; end
    tick;
  endtask

  task automatic test_round_robin;
    int k = 0;
    logic [1:0] ei;
    logic [3:0] ep;
    for (int c = 0; c < 12; c++) begin
      drive(4'b1111, 4'b1111, 1'b1, 1'b1);
      n_vec++;
      if (obs !== expv) begin $display("FAIL rr_cycle%0d obs=%h exp=%h", c, obs, expv); n_err++; end
      if (out_vld && out_rdy) begin
        ei = 2'(k % 4);
        ep = 4'(1 << (k % 4));
        n_vec++;
        if (out_idx !== ei || prio !== ep) begin
          $display("FAIL rr_order idx=%0d prio=%b exp_idx=%0d exp_prio=%b", out_idx, prio, ei, ep);
          n_err++;
        end
        k++;
      end
      tick;
    end
    n_vec++;
    if (k != 6) begin $display("FAIL rr_count got=%0d exp=6", k); n_err++; end
  endtask

  task automatic test_wrap;
    for (int c = 0; c < 2; c++) begin
      drive(4'b0100, 4'b0100, 1'b1, 1'b1);
      n_vec++;
      if (obs !== expv) begin $display("FAIL wrap_pre obs=%h exp=%h", obs, expv); n_err++; end
      tick;
    end
    drive(4'b0101, 4'b0101, 1'b1, 1'b1);
    n_vec++;
    if (prio !== 4'b1000) begin $display("FAIL wrap_prio0 got=%b exp=1000", prio); n_err++; end
    tick;
    drive(4'b0101, 4'b0101, 1'b1, 1'b1);
    n_vec++;
    if (out_owner !== 4'b0001 || obs !== expv) begin
      $display("FAIL wrap_owner got=%b obs=%h exp=%h", out_owner, obs, expv); n_err++;
    end
    tick;
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    n_vec++;
    if (prio !== 4'b0010) begin $display("FAIL wrap_prio1 got=%b exp=0010", prio); n_err++; end
    tick;
  endtask

  task automatic test_backpressure;
    int x = 0;
    for (int i = 0; i < 9; i++) begin
      drive(4'b1010, (x == 2) ? 4'b0010 : 4'b0000, (i % 2) == 0, 1'b1);
      n_vec++;
      if (obs !== expv) begin $display("FAIL bp_cycle%0d obs=%h exp=%h", i, obs, expv); n_err++; end
      if (x < 3) begin
        n_vec++;
        if (req_rdy[3] !== 1'b0) begin $display("FAIL bp_rdy3 got=%b exp=0", req_rdy[3]); n_err++; end
      end
      if (out_vld && out_rdy && out_idx == 2'd1) x++;
      tick;
    end
    n_vec++;
    if (x != 3) begin $display("FAIL bp_beats got=%0d exp=3", x); n_err++; end
    drive(4'b1000, 4'b1000, 1'b1, 1'b1);
    n_vec++;
    if (out_owner !== 4'b1000) begin $display("FAIL bp_next got=%b exp=1000", out_owner); n_err++; end
    tick;
  endtask

  task automatic test_watchdog;
    drive(4'b0100, 4'b0000, 1'b1, 1'b1); tick;
    drive(4'b0100, 4'b0000, 1'b1, 1'b1);
    n_vec++;
    if (obs !== expv) begin $display("FAIL wd_beat obs=%h exp=%h", obs, expv); n_err++; end
    tick;
    for (int j = 1; j <= 18; j++) begin
      drive(4'b0000, 4'b0000, 1'b1, 1'b1);
      n_vec++;
      if (err_timeout !== (j == 16) || obs !== expv) begin
        $display("FAIL wd_idle%0d err=%b obs=%h exp=%h", j, err_timeout, obs, expv); n_err++;
      end
      if (j == 17) begin
        n_vec++;
        if (busy !== 1'b0 || prio !== 4'b1000) begin
          $display("FAIL wd_release busy=%b prio=%b exp busy=0 prio=1000", busy, prio); n_err++;
        end
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    drive(4'b0010, 4'b0000, 1'b1, 1'b1); tick;
    drive(4'b0010, 4'b0000, 1'b1, 1'b1); tick;
    drive(4'b0010, 4'b0000, 1'b1, 1'b0);
    n_vec++;
    if (out_vld !== 1'b0 || req_rdy !== 4'b0000) begin
      $display("FAIL rstmid_accept vld=%b rdy=%b exp 0", out_vld, req_rdy); n_err++;
    end
    tick;
    drive(4'b0010, 4'b0000, 1'b1, 1'b1);
    n_vec++;
    if (busy !== 1'b0 || out_owner !== 4'b0000 || prio !== 4'b0001 || out_vld !== 1'b0) begin
      $display("FAIL rstmid_state busy=%b own=%b prio=%b vld=%b", busy, out_owner, prio, out_vld);
      n_err++;
    end
    tick;
    drive(4'b0010, 4'b0010, 1'b1, 1'b1);
    n_vec++;
    if (out_owner !== 4'b0010 || out_vld !== 1'b1 || obs !== expv) begin
      $display("FAIL rstmid_regrant obs=%h exp=%h", obs, expv); n_err++;
    end
    tick;
  endtask

  task automatic test_lone;
    int x = 0;
    for (int c = 0; c < 10; c++) begin
      drive(4'b0100, 4'b0100, 1'b1, 1'b1);
      n_vec++;
      if (err_timeout !== 1'b0 || obs !== expv) begin
        $display("FAIL lone_cycle%0d obs=%h exp=%h", c, obs, expv); n_err++;
      end
      if (out_vld && out_rdy) x++;
      tick;
    end
    n_vec++;
    if (x != 5) begin $display("FAIL lone_count got=%0d exp=5", x); n_err++; end
  endtask

  task automatic test_random;
    logic [3:0] v, l;
    for (int c = 0; c < 600; c++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = '0;
      l = 4'($urandom_range(0, 15));
      drive(v, l, 1'($urandom_range(0, 1)), $urandom_range(0, 59) != 0);
      n_vec++;
      if (obs !== expv) begin $display("FAIL rand_cycle%0d obs=%h exp=%h", c, obs, expv); n_err++; end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_wrap;
    test_backpressure;
    test_watchdog;
    test_reset_mid;
    test_lone;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
